// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: producer-side and transmitter-side signals of the UART
// transmit queue, grouped so that the queue and its neighbours share one bundle.
// The slave modport is the queue itself. The master modport is the
// producer/transmitter side that drives wr_en, wr_data and tx_done_tick.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          tx_start;
    logic [7:0]    din;
    logic          tx_done_tick;
    logic          busy;
    logic          overflow;

    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, count, tx_start, din, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, count, tx_start, din, busy, overflow
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO and launch controller that sits in front of a UART
// transmitter. Queued bytes are presented one at a time on din. A tx_start
// level is raised for each byte, and din is held until tx_done_tick. An
// optional idle gap of GAP_CYCLES clocks follows each byte.
//
// Optional feature: define UART_TXQ_OVERFLOW_EN to build a sticky overflow
// flag that records writes attempted while full. Without it, overflow is tied
// to 0 and such writes are simply dropped.
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input logic            clk,
    input logic            rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          tx_start;
    logic          busy;
    logic [7:0]    din;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // full and empty come only from the registered count. There is no
    // combinational path from wr_en to either flag.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // full is taken from the pre-edge count, so a pop in the same cycle does
    // not make room for a write to a full queue.
    assign push = bus.wr_en && !full;
    assign pop  = (state == IDLE) && !empty;

    // Storage array. Reset leaves the contents alone because the pointers
    // and count already make them unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers wrap naturally at DEPTH-1. count tracks the occupancy and
    // excludes the byte currently in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Launch controller. din, tx_start and busy are all registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            tx_start <= 1'b0;
            din      <= 8'h00;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        din      <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // din is not touched in this state. It stays put until
                    // the transmitter reports the stop bit.
                    if (bus.tx_done_tick) begin
                        tx_start <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic overflow;

    // Sticky record of any write attempted while the queue was full.
    always_ff @(posedge clk) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (bus.wr_en && full)
            overflow <= 1'b1;
    end

    assign bus.overflow = overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.tx_start = tx_start;
    assign bus.din      = din;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: drives two queues (GAP_CYCLES=0 and GAP_CYCLES=4) and
// compares their outputs every cycle against a list-based reference model.
// Directed scenarios are followed by a randomized phase.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TXQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en_s   [2];
    logic [7:0] wr_data_s [2];
    logic       done_s    [2];

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) if0 ();
    uart_tx_queue_if #(.DEPTH(DEPTH)) if1 ();

    assign if0.wr_en        = wr_en_s[0];
    assign if0.wr_data      = wr_data_s[0];
    assign if0.tx_done_tick = done_s[0];
    assign if1.wr_en        = wr_en_s[1];
    assign if1.wr_data      = wr_data_s[1];
    assign if1.tx_done_tick = done_s[1];

    uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Reference model. Each queue is kept as an append-only list between head and tail.
    logic [7:0] m_buf  [2][4096];
    int         m_head [2];
    int         m_tail [2];
    int         m_gap  [2];
    bit         m_send [2];
    logic [7:0] m_din  [2];
    bit         m_ovf  [2];

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] tx_log[$];
    bit         prev_start0 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step(input int i, input bit wr, input logic [7:0] d, input bit done);
        int  g;
        int  size;
        bit  is_full;
        g = (i == 0) ? 0 : 4;
        if (!rst_n) begin
            m_head[i] = 0; m_tail[i] = 0; m_gap[i] = 0;
            m_send[i] = 0; m_din[i] = 8'h00; m_ovf[i] = 0;
            return;
        end
        size    = m_tail[i] - m_head[i];
        is_full = (size == DEPTH);
        if (wr && is_full) m_ovf[i] = 1;
        if (m_send[i]) begin
            if (done) begin
                m_send[i] = 0;
                m_gap[i]  = g;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end else if (size > 0) begin
            m_din[i] = m_buf[i][m_head[i]];
            m_head[i]++;
            m_send[i] = 1;
        end
        if (wr && !is_full && m_tail[i] < 4096) begin
            m_buf[i][m_tail[i]] = d;
            m_tail[i]++;
        end
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        int size;
        size = m_tail[i] - m_head[i];
        return {14'd0, m_send[i], (m_send[i] || m_gap[i] > 0), (size == 0), (size == DEPTH),
                (OVF_EN && m_ovf[i]), CW'(size), m_din[i]};
    endfunction

    function automatic logic [31:0] got_vec(input int i);
        if (i == 0)
            return {14'd0, if0.tx_start, if0.busy, if0.empty, if0.full, if0.overflow, if0.count, if0.din};
        return {14'd0, if1.tx_start, if1.busy, if1.empty, if1.full, if1.overflow, if1.count, if1.din};
    endfunction

    function automatic logic start_of(input int i);
        return (i == 0) ? if0.tx_start : if1.tx_start;
    endfunction

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, wr_en_s[i], wr_data_s[i], done_s[i]);
        #1;
        chk("outs_gap0", got_vec(0), exp_vec(0));
        chk("outs_gap4", got_vec(1), exp_vec(1));
        if (if0.tx_start && !prev_start0) tx_log.push_back(if0.din);
        prev_start0 = if0.tx_start;
        for (int i = 0; i < 2; i++) begin
            wr_en_s[i] = 1'b0;
            done_s[i]  = 1'b0;
        end
    endtask

    task automatic wr(input int i, input logic [7:0] d);
        wr_en_s[i]   = 1'b1;
        wr_data_s[i] = d;
        cyc();
    endtask

    task automatic wait_start(input int i, input string tag);
        int n = 0;
        while (start_of(i) !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, start_of(i)}, 1);
    endtask

    // Transmitter stand-in for the gap-0 queue: done arrives 20 clk after each launch.
    task automatic serve0(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            wait_start(0, "serve_start");
            repeat (19) cyc();
            done_s[0] = 1'b1;
            cyc();
        end
    endtask

    task automatic count_low(input int i, output int lo);
        lo = 0;
        while (start_of(i) !== 1'b1 && lo < 50) begin
            lo++;
            cyc();
        end
    endtask

    initial begin
        int lo;
        for (int i = 0; i < 2; i++) begin
            wr_en_s[i] = 1'b0; wr_data_s[i] = 8'h00; done_s[i] = 1'b0;
        end

        // Reset state.
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_start", {31'd0, if0.tx_start}, 0);
        chk("rst_empty", {31'd0, if0.empty}, 1);
        chk("rst_full",  {31'd0, if0.full}, 0);
        chk("rst_count", {27'd0, if0.count}, 0);
        chk("rst_din",   {24'd0, if0.din}, 32'h00);
        chk("rst_busy",  {31'd0, if0.busy}, 0);
        chk("rst_ovf",   {31'd0, if0.overflow}, 0);
        rst_n = 1'b1;
        cyc();

        // Single write latency.
        wr(0, 8'hA5);
        chk("lat_cnt1",  {27'd0, if0.count}, 1);
        chk("lat_idle",  {31'd0, if0.tx_start}, 0);
        cyc();
        chk("lat_start", {31'd0, if0.tx_start}, 1);
        chk("lat_din",   {24'd0, if0.din}, 32'hA5);
        chk("lat_cnt0",  {27'd0, if0.count}, 0);
        chk("lat_busy",  {31'd0, if0.busy}, 1);
        repeat (3) cyc();
        done_s[0] = 1'b1;
        cyc();
        chk("done_drop", {31'd0, if0.tx_start}, 0);
        chk("done_idle", {31'd0, if0.busy}, 0);

        // Back-to-back with no gap: tx_start low for exactly one clock.
        wr(0, 8'h11);
        wr(0, 8'h22);
        repeat (2) cyc();
        done_s[0] = 1'b1;
        cyc();
        count_low(0, lo);
        chk("gap0_low", lo, 1);
        chk("b2b_din", {24'd0, if0.din}, 32'h22);
        serve0(1);

        // Burst 01..10 in order.
        tx_log.delete();
        for (int k = 1; k <= 16; k++) wr(0, 8'(k));
        chk("burst_cnt",  {27'd0, if0.count}, 15);
        chk("burst_full", {31'd0, if0.full}, 0);
        serve0(16);
        chk("burst_n", tx_log.size(), 16);
        for (int k = 0; k < 16 && k < tx_log.size(); k++)
            chk("burst_ord", {24'd0, tx_log[k]}, k + 1);
        chk("burst_cnt0",  {27'd0, if0.count}, 0);
        chk("burst_empty", {31'd0, if0.empty}, 1);

        // Fill to full, then a rejected write.
        tx_log.delete();
        for (int k = 0; k < 17; k++) wr(0, 8'(8'h20 + k));
        chk("fill_cnt",  {27'd0, if0.count}, 16);
        chk("fill_full", {31'd0, if0.full}, 1);
        wr(0, 8'hFF);
        chk("ovr_cnt",  {27'd0, if0.count}, 16);
        chk("ovr_flag", {31'd0, if0.overflow}, {31'd0, OVF_EN});
        serve0(17);
        chk("fill_n", tx_log.size(), 17);
        for (int k = 0; k < 17 && k < tx_log.size(); k++)
            chk("fill_ord", {24'd0, tx_log[k]}, 32'h20 + k);

        // Simultaneous write and pop with three queued.
        for (int k = 0; k < 4; k++) wr(0, 8'(8'h40 + k));
        chk("sim_pre", {27'd0, if0.count}, 3);
        done_s[0] = 1'b1;
        cyc();
        chk("sim_idle", {27'd0, if0.count}, 3);
        wr(0, 8'h44);
        chk("sim_cnt", {27'd0, if0.count}, 3);
        chk("sim_din", {24'd0, if0.din}, 32'h41);
        serve0(4);

        // Gap of four on the second queue: tx_start low for five clocks.
        wr(1, 8'h55);
        wr(1, 8'h66);
        wait_start(1, "g4_first");
        repeat (3) cyc();
        done_s[1] = 1'b1;
        cyc();
        count_low(1, lo);
        chk("gap4_low", lo, 5);
        chk("gap4_din", {24'd0, if1.din}, 32'h66);
        repeat (3) cyc();
        done_s[1] = 1'b1;
        cyc();

        // Reset during SEND with five queued.
        for (int k = 0; k < 6; k++) wr(0, 8'(8'h70 + k));
        chk("rs_pre", {27'd0, if0.count}, 5);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rs_start", {31'd0, if0.tx_start}, 0);
        chk("rs_count", {27'd0, if0.count}, 0);
        chk("rs_din",   {24'd0, if0.din}, 32'h00);
        done_s[0] = 1'b1;
        cyc();
        cyc();
        chk("rs_stray", {31'd0, if0.tx_start}, 0);
        chk("rs_busy",  {31'd0, if0.busy}, 0);

        // Randomized traffic on both queues, including stray done pulses.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                wr_en_s[i]   = ($urandom_range(0, 2) == 0);
                wr_data_s[i] = 8'($urandom);
                done_s[i]    = ($urandom_range(0, 5) == 0);
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer via a write strobe, buffers up to DEPTH bytes, and presents one byte at a time on din with a level tx_start.
- Holds din stable until the transmitter pulses tx_done_tick, then optionally waits GAP_CYCLES before launching the next byte.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 0, idle clk cycles inserted between tx_done_tick and the next launch; 0 means no gap.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write strobe; byte accepted when wr_en=1 and full=0.
- wr_data  in  8  byte to enqueue.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  $clog2(DEPTH)+1  bytes held in FIFO; excludes the byte in flight.
- tx_start  out  1  level request to the transmitter.
- din  out  8  byte in flight; stable while busy=1.
- tx_done_tick  in  1  one-clk pulse from the transmitter at end of stop bit.
- busy  out  1  high in SEND and GAP states.
- overflow  out  1  sticky flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0 sampled at a posedge):
  - Read and write pointers and count go to 0.
  - State goes to IDLE; gap counter goes to 0.
  - Outputs: tx_start=0, din=8'h00, busy=0, empty=1, full=0, overflow=0.
  - Reset has priority over every other input in that cycle.
- Reset mid-transmission drops the in-flight byte and all queued bytes. The transmitter is reset from the same source.
- Storage:
  - DEPTH x 8 register array.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
  - count is tracked separately.
- Write: wr_en and !full stores wr_data at wr_ptr, increments wr_ptr and increments count. wr_en while full leaves the FIFO unchanged.
- State machine, states IDLE, SEND, GAP:
  - IDLE: if !empty, then din<=mem[rd_ptr], rd_ptr++, count--, tx_start<=1, go to SEND. Otherwise stay; tx_start=0.
  - SEND: tx_start stays 1 and din is held. On tx_done_tick=1, tx_start<=0. Then, if GAP_CYCLES==0, go to IDLE; otherwise load gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: decrement gap counter each clk; at 0, go to IDLE. tx_start=0.
  - tx_done_tick outside SEND is ignored.
- Simultaneous write and pop in one cycle:
  - count is unchanged; both pointers advance.
  - A write while full in the same cycle as a pop is still rejected, because full is evaluated on the pre-edge count.
- Latency:
  - Write sampled at edge E0 with the FIFO empty and state IDLE: count=1 after E0.
  - Pop at E1: tx_start=1 and din valid after E1, i.e. 2 clk edges after the write.
  - Back-to-back with GAP_CYCLES=0: the next tx_start rises on the edge after the one that sampled tx_done_tick, so tx_start is low for exactly 1 clk.
- tx_start is a level, not a pulse. The transmitter samples it only on its internal baud window, so holding it guarantees the request is not missed.
- din is registered and never changes in SEND.
- full, empty and count are registered or derived from registered count; no combinational path from wr_en.

Optional Feature:
- Macro UART_TXQ_OVERFLOW_EN.
- Defined: overflow is set on any edge where wr_en=1 and full=1. It stays set until rst_n=0.
- Undefined: overflow is tied to 0 and no flag register is built. Writes while full are still silently dropped.

Test Plan:
- Reset then single write 8'hA5 at edge E0:
  - count=1 after E0.
  - tx_start=1, din=8'hA5, count=0, busy=1 after E1.
  - Pulse tx_done_tick -> tx_start=0 the next edge; state back to IDLE.
- Burst-write 8'h01..8'h10 with DEPTH=16, responding with tx_done_tick 20 clk after each tx_start rise:
  - din sequence is 8'h01..8'h10 in order.
  - full=1 only after 16 stored entries while the first byte is not yet popped.
  - Final count=0, empty=1.
- Fill to full, then write 8'hFF:
  - FIFO contents unchanged; 8'hFF is never transmitted.
  - overflow=1 with UART_TXQ_OVERFLOW_EN, overflow=0 without.
- Simultaneous wr_en and pop with count=3 -> count stays 3; pointer wrap past DEPTH-1 preserves byte order.
- GAP_CYCLES=4 with two queued bytes -> tx_start is low for exactly 5 clk between tx_done_tick being sampled and the second launch.
- Assert rst_n=0 during SEND with 5 queued bytes:
  - Next edge: tx_start=0, count=0, din=8'h00.
  - A stray tx_done_tick after reset has no effect.
